// File: rtl/se_drv_pkg.sv
// Shared types and defaults for the self-composition stimulus driver.
// The optional leak-statistics block is enabled by defining SE_DRV_LEAK_STICKY_EN.
package se_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } se_drv_state_e;

    localparam int SE_DRV_DATA_W  = 128;
    localparam int SE_DRV_INST_W  = 8;
    localparam int SE_DRV_CNT_W   = 16;
    localparam int SE_DRV_TIMEOUT = 1024;

    localparam logic [SE_DRV_CNT_W-1:0] SE_DRV_LAT_SAT = {SE_DRV_CNT_W{1'b1}};

    // Saturating increment for the default counter width.
    function automatic logic [SE_DRV_CNT_W-1:0] se_drv_sat_inc(input logic [SE_DRV_CNT_W-1:0] v);
        logic [SE_DRV_CNT_W-1:0] r;
        if (v == SE_DRV_LAT_SAT) begin
            r = v;
        end else begin
            r = v + {{(SE_DRV_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/se_drv_lane.sv
// One SE lane: issues the request over the input handshake, then collects the result
// and the cycle counter value seen on the output handshake.
module se_drv_lane
    import se_drv_pkg::*;
#(
    parameter int DATA_W = SE_DRV_DATA_W,
    parameter int CNT_W  = SE_DRV_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              exit_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              in_ready_i,
    input  logic              out_valid_i,
    input  logic [DATA_W-1:0] out_result_i,
    output logic              in_valid_o,
    output logic              out_ready_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  lat_o,
    output logic [DATA_W-1:0] result_o
);

    logic              in_valid_q,  in_valid_d;
    logic              out_ready_q, out_ready_d;
    logic              done_q,      done_d;
    logic [CNT_W-1:0]  lat_q,       lat_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic              out_hs_s;

    // Values as they stand at the end of this cycle, so the top can report without a bubble.
    always_comb begin
        out_hs_s = out_valid_i & out_ready_q;
        done_o   = done_q | out_hs_s;
        if (out_hs_s) begin
            lat_o    = cnt_i;
            result_o = out_result_i;
        end else begin
            lat_o    = lat_q;
            result_o = result_q;
        end
    end

    assign in_valid_o  = in_valid_q;
    assign out_ready_o = out_ready_q;

    // Next-state logic; an undone lane keeps the saturated latency and a zero result.
    always_comb begin
        in_valid_d  = in_valid_q;
        out_ready_d = out_ready_q;
        done_d      = done_q;
        lat_d       = lat_q;
        result_d    = result_q;
        if (start_i) begin
            in_valid_d  = 1'b1;
            out_ready_d = 1'b0;
            done_d      = 1'b0;
            lat_d       = {CNT_W{1'b1}};
            result_d    = {DATA_W{1'b0}};
        end else if (exit_i) begin
            in_valid_d  = 1'b0;
            out_ready_d = 1'b0;
            done_d      = done_o;
            lat_d       = lat_o;
            result_d    = result_o;
        end else begin
            if (in_valid_q && in_ready_i) begin
                in_valid_d  = 1'b0;
                out_ready_d = 1'b1;
            end else begin
                in_valid_d  = in_valid_q;
            end
            if (out_hs_s) begin
                out_ready_d = 1'b0;
                done_d      = 1'b1;
                lat_d       = cnt_i;
                result_d    = out_result_i;
            end else begin
                done_d      = done_q;
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b0;
            done_q      <= 1'b0;
            lat_q       <= {CNT_W{1'b0}};
            result_q    <= {DATA_W{1'b0}};
        end else begin
            in_valid_q  <= in_valid_d;
            out_ready_q <= out_ready_d;
            done_q      <= done_d;
            lat_q       <= lat_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: rtl/se_selfcomp_driver.sv
// Drives one request into two SE copies and reports per-lane latency, skew and leak.
// Define SE_DRV_LEAK_STICKY_EN to keep a sticky leak flag and a saturating leak counter.
module se_selfcomp_driver
    import se_drv_pkg::*;
#(
    parameter int DATA_W  = SE_DRV_DATA_W,
    parameter int INST_W  = SE_DRV_INST_W,
    parameter int CNT_W   = SE_DRV_CNT_W,
    parameter int TIMEOUT = SE_DRV_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [INST_W-1:0] req_inst,
    input  logic [DATA_W-1:0] req_op2,
    input  logic [DATA_W-1:0] req_cond,
    input  logic [DATA_W-1:0] req_op1_a,
    input  logic [DATA_W-1:0] req_op1_b,
    output logic              se_in_valid_a,
    output logic              se_in_valid_b,
    input  logic              se_in_ready_a,
    input  logic              se_in_ready_b,
    output logic [INST_W-1:0] se_in_inst,
    output logic [DATA_W-1:0] se_in_op2,
    output logic [DATA_W-1:0] se_in_cond,
    output logic [DATA_W-1:0] se_in_op1_a,
    output logic [DATA_W-1:0] se_in_op1_b,
    input  logic              se_out_valid_a,
    input  logic              se_out_valid_b,
    output logic              se_out_ready_a,
    output logic              se_out_ready_b,
    input  logic [DATA_W-1:0] se_out_result_a,
    input  logic [DATA_W-1:0] se_out_result_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result_a,
    output logic [DATA_W-1:0] rsp_result_b,
    output logic [CNT_W-1:0]  rsp_lat_a,
    output logic [CNT_W-1:0]  rsp_lat_b,
    output logic [CNT_W-1:0]  rsp_skew,
    output logic              rsp_leak,
    output logic              rsp_timeout,
    output logic              leak_sticky,
    output logic [CNT_W-1:0]  leak_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    se_drv_state_e     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic [INST_W-1:0] inst_q;
    logic [DATA_W-1:0] op2_q, cond_q, op1_a_q, op1_b_q;
    logic              rsp_valid_q, rsp_leak_q, rsp_timeout_q;
    logic [DATA_W-1:0] rsp_result_a_q, rsp_result_b_q;
    logic [CNT_W-1:0]  rsp_lat_a_q, rsp_lat_b_q, rsp_skew_q;

    logic              start_s, exit_s, all_done_s, tmo_hit_s;
    logic              done_a_s, done_b_s;
    logic [CNT_W-1:0]  lat_a_s, lat_b_s, skew_s;
    logic [DATA_W-1:0] res_a_s, res_b_s;

    se_drv_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane_a (
        .clk_i        (clock),
        .rst_ni       (reset),
        .start_i      (start_s),
        .exit_i       (exit_s),
        .cnt_i        (cnt_q),
        .in_ready_i   (se_in_ready_a),
        .out_valid_i  (se_out_valid_a),
        .out_result_i (se_out_result_a),
        .in_valid_o   (se_in_valid_a),
        .out_ready_o  (se_out_ready_a),
        .done_o       (done_a_s),
        .lat_o        (lat_a_s),
        .result_o     (res_a_s)
    );

    se_drv_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane_b (
        .clk_i        (clock),
        .rst_ni       (reset),
        .start_i      (start_s),
        .exit_i       (exit_s),
        .cnt_i        (cnt_q),
        .in_ready_i   (se_in_ready_b),
        .out_valid_i  (se_out_valid_b),
        .out_result_i (se_out_result_b),
        .in_valid_o   (se_in_valid_b),
        .out_ready_o  (se_out_ready_b),
        .done_o       (done_b_s),
        .lat_o        (lat_b_s),
        .result_o     (res_b_s)
    );

    // A lane finishing on the last allowed cycle counts as done, not timed out.
    always_comb begin
        start_s    = (state_q == IDLE) && req_valid;
        all_done_s = done_a_s && done_b_s;
        tmo_hit_s  = (cnt_q == CNT_LAST) && !all_done_s;
        exit_s     = (state_q == RUN) && (all_done_s || tmo_hit_s);
        if (lat_a_s >= lat_b_s) begin
            skew_s = lat_a_s - lat_b_s;
        end else begin
            skew_s = lat_b_s - lat_a_s;
        end
    end

    // Request/response FSM with the RUN-cycle counter and registered report fields.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= {CNT_W{1'b0}};
            req_ready_q    <= 1'b1;
            inst_q         <= {INST_W{1'b0}};
            op2_q          <= {DATA_W{1'b0}};
            cond_q         <= {DATA_W{1'b0}};
            op1_a_q        <= {DATA_W{1'b0}};
            op1_b_q        <= {DATA_W{1'b0}};
            rsp_valid_q    <= 1'b0;
            rsp_result_a_q <= {DATA_W{1'b0}};
            rsp_result_b_q <= {DATA_W{1'b0}};
            rsp_lat_a_q    <= {CNT_W{1'b0}};
            rsp_lat_b_q    <= {CNT_W{1'b0}};
            rsp_skew_q     <= {CNT_W{1'b0}};
            rsp_leak_q     <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        inst_q      <= req_inst;
                        op2_q       <= req_op2;
                        cond_q      <= req_cond;
                        op1_a_q     <= req_op1_a;
                        op1_b_q     <= req_op1_b;
                        cnt_q       <= {CNT_W{1'b0}};
                        req_ready_q <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                    if (exit_s) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_result_a_q <= res_a_s;
                        rsp_result_b_q <= res_b_s;
                        rsp_lat_a_q    <= lat_a_s;
                        rsp_lat_b_q    <= lat_b_s;
                        rsp_skew_q     <= skew_s;
                        rsp_leak_q     <= (lat_a_s != lat_b_s) || !all_done_s;
                        rsp_timeout_q  <= !all_done_s;
                        state_q        <= REPORT;
                    end
                end
                REPORT: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef SE_DRV_LEAK_STICKY_EN
    logic             leak_sticky_q;
    logic [CNT_W-1:0] leak_count_q;

    // Leak statistics, updated only on a consumed leaky report.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leak_sticky_q <= 1'b0;
            leak_count_q  <= {CNT_W{1'b0}};
        end else if (rsp_valid_q && rsp_ready && rsp_leak_q) begin
            leak_sticky_q <= 1'b1;
            if (leak_count_q != CNT_SAT) begin
                leak_count_q <= leak_count_q + CNT_ONE;
            end
        end
    end

    assign leak_sticky = leak_sticky_q;
    assign leak_count  = leak_count_q;
`else
    assign leak_sticky = 1'b0;
    assign leak_count  = {CNT_W{1'b0}};
`endif

    assign req_ready    = req_ready_q;
    assign se_in_inst   = inst_q;
    assign se_in_op2    = op2_q;
    assign se_in_cond   = cond_q;
    assign se_in_op1_a  = op1_a_q;
    assign se_in_op1_b  = op1_b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result_a = rsp_result_a_q;
    assign rsp_result_b = rsp_result_b_q;
    assign rsp_lat_a    = rsp_lat_a_q;
    assign rsp_lat_b    = rsp_lat_b_q;
    assign rsp_skew     = rsp_skew_q;
    assign rsp_leak     = rsp_leak_q;
    assign rsp_timeout  = rsp_timeout_q;

endmodule
